param_rr_mux_reg: RTL and testbench

Parametrised W-bit, N-channel registered multiplexer with per-channel valid/ready handshake. Channel selection is either round-robin arbitration or an externally forced channel.
Generalises the fixed 8-bit 16:1 combinational select tree. Adds a registered output, backpressure and fair arbitration.
Sits between multiple producer blocks (ALU/register-file read ports, I/O channels) and a single shared consumer.

---
 rtl/mux_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/param_rr_mux_reg.sv | 93 +++++++++
 tb/tb_param_rr_mux_reg.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared helpers for the channel multiplexer family: index width, mode
// encoding and index-to-one-hot conversion.
package mux_pkg;

   localparam int   MAX_NCH    = 256;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Caller slices the low NCH bits; indices past MAX_NCH give all-zero.
   function automatic logic [MAX_NCH-1:0] idx_to_onehot(input int unsigned idx);
      logic [MAX_NCH-1:0] oh;
      oh = '0;
      if (idx < MAX_NCH) oh = {{(MAX_NCH-1){1'b0}}, 1'b1} << idx;
      return oh;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// above ptr, wrapping modulo NCH (NCH need not be a power of two).
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int NCH  = 16,
   localparam int SELW = clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [NCH-1:0]  grant,
   output logic [SELW-1:0] grant_idx
);

   int              idx;
   logic            found;
   logic [SELW-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      cand      = '0;
      for (int k = 0; k < NCH; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NCH) idx = idx - NCH;
         cand = SELW'(idx);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/param_rr_mux_reg.sv
// N-channel, W-bit registered multiplexer with valid/ready on every channel,
// selecting by round-robin or by a forced channel index.
module param_rr_mux_reg
   import mux_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NCH   = 16,
   localparam int SELW  = clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 rr_en,
   input  logic [SELW-1:0]      fix_sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [SELW-1:0]    ptr_p1;
   logic [NCH-1:0]     rr_grant;
   logic [SELW-1:0]    rr_idx;
   logic [MAX_NCH-1:0] fix_oh;
   logic [NCH-1:0]     grant;
   logic [SELW-1:0]    grant_idx;
   logic               can_load;
   logic               accept;
   logic signed [WIDTH-1:0] sel_data;
   logic signed [WIDTH-1:0] data_p1;
   logic [SELW-1:0]    sel_p1;
   logic               vld_p1;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req       (in_valid),
      .ptr       (ptr_p1),
      .grant     (rr_grant),
      .grant_idx (rr_idx)
   );

   assign fix_oh = idx_to_onehot(int'(fix_sel));

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      if (rr_en == MODE_RR) begin
         grant     = rr_grant;
         grant_idx = rr_idx;
      end else if (int'(fix_sel) < NCH) begin
         grant     = fix_oh[NCH-1:0] & in_valid;
         grant_idx = fix_sel;
      end
   end

   assign can_load = !vld_p1 || out_ready;
   assign in_ready = grant & {NCH{can_load & !reset}};
   assign accept   = |in_ready;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NCH; i++) begin
         sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
      end
   end

   // Stage p1: single output slot and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_p1 <= '0;
         sel_p1  <= '0;
         vld_p1  <= 1'b0;
         ptr_p1  <= '0;
      end else begin
         if (accept) begin
            data_p1 <= sel_data;
            sel_p1  <= grant_idx;
            vld_p1  <= 1'b1;
         end else if (out_ready) begin
            vld_p1  <= 1'b0;
         end
         if (accept && rr_en == MODE_RR) begin
            ptr_p1 <= (rr_idx == SELW'(NCH-1)) ? '0 : rr_idx + 1'b1;
         end
      end
   end

   assign out_data  = data_p1;
   assign out_sel   = sel_p1;
   assign out_valid = vld_p1;

endmodule

// File: tb/tb_param_rr_mux_reg.sv
// Directed bench for param_rr_mux_reg: a 16x8 instance for the main
// behaviour and a 5x12 instance for the non-power-of-two sweep.
module tb_param_rr_mux_reg;

   logic clk;
   logic reset;

   logic [127:0] in_data;
   logic [15:0]  in_valid;
   logic [15:0]  in_ready;
   logic         rr_en;
   logic [3:0]   fix_sel;
   logic [7:0]   out_data;
   logic [3:0]   out_sel;
   logic         out_valid;
   logic         out_ready;

   logic [59:0]  in_data5;
   logic [4:0]   in_valid5;
   logic [4:0]   in_ready5;
   logic         rr_en5;
   logic [2:0]   fix_sel5;
   logic [11:0]  out_data5;
   logic [2:0]   out_sel5;
   logic         out_valid5;
   logic         out_ready5;

   int n_chk;
   int n_err;

   param_rr_mux_reg #(.WIDTH(8), .NCH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rr_en     (rr_en),
      .fix_sel   (fix_sel),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   param_rr_mux_reg #(.WIDTH(12), .NCH(5)) dut5 (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data5),
      .in_valid  (in_valid5),
      .in_ready  (in_ready5),
      .rr_en     (rr_en5),
      .fix_sel   (fix_sel5),
      .out_data  (out_data5),
      .out_sel   (out_sel5),
      .out_valid (out_valid5),
      .out_ready (out_ready5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] word16(input int ch);
      return (ch == 5) ? 8'hA5 : 8'(8'h30 + ch);
   endfunction

   function automatic logic [11:0] word5(input int ch);
      return 12'(12'hA00 + 17 * ch);
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Producer rule: data of a waiting channel must not move.
   logic [15:0]  pend_q = '0;
   logic [127:0] data_q = '0;
   always @(negedge clk) begin
      for (int i = 0; i < 16; i++) begin
         if (pend_q[i] && in_valid[i])
            assert (in_data[i*8 +: 8] == data_q[i*8 +: 8])
               else $error("producer data changed while waiting on ch %0d", i);
      end
      pend_q <= in_valid & ~in_ready;
      data_q <= in_data;
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      reset = 1'b1;
      for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = word16(i);
      for (int i = 0; i < 5; i++)  in_data5[i*12 +: 12] = word5(i);
      in_valid   = 16'hFFFF;
      rr_en      = 1'b1;
      fix_sel    = 4'd0;
      out_ready  = 1'b1;
      in_valid5  = '0;
      rr_en5     = 1'b0;
      fix_sel5   = '0;
      out_ready5 = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_sel", 32'(out_sel), 32'h0);
      reset    = 1'b0;
      in_valid = '0;

      // Fixed select of channel 5
      rr_en    = 1'b0;
      fix_sel  = 4'd5;
      in_valid = 16'hFFFF;
      #1;
      chk("fix_in_ready", 32'(in_ready), 32'h0020);
      step();
      chk("fix_data", 32'(out_data), 32'hA5);
      chk("fix_sel", 32'(out_sel), 32'd5);
      chk("fix_valid", 32'(out_valid), 32'h1);
      in_valid = '0;
      step();
      chk("drain_valid", 32'(out_valid), 32'h0);
      chk("drain_hold", 32'(out_data), 32'hA5);

      // Round-robin over all channels; ptr must still be 0
      rr_en    = 1'b1;
      in_valid = 16'hFFFF;
      for (int k = 0; k < 17; k++) begin
         #1;
         chk("rr_in_ready", 32'(in_ready), 32'h1 << (k % 16));
         step();
         chk("rr_sel", 32'(out_sel), 32'(k % 16));
         chk("rr_data", 32'(out_data), 32'(word16(k % 16)));
         chk("rr_valid", 32'(out_valid), 32'h1);
      end

      // Move ptr to 15, then sparse requests on 3 and 14
      in_valid = 16'h4000;
      step();
      chk("ptr15_sel", 32'(out_sel), 32'd14);
      in_valid = 16'h4008;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("sparse_sel", 32'(out_sel), (k % 2 == 0) ? 32'd3 : 32'd14);
      end

      // Backpressure on a held word from channel 14
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("stall_in_ready", 32'(in_ready), 32'h0);
         step();
         chk("stall_data", 32'(out_data), 32'(word16(14)));
         chk("stall_sel", 32'(out_sel), 32'd14);
         chk("stall_valid", 32'(out_valid), 32'h1);
      end
      out_ready = 1'b1;
      #1;
      chk("unstall_in_ready", 32'(in_ready), 32'h0008);
      step();
      chk("unstall_sel", 32'(out_sel), 32'd3);
      chk("unstall_data", 32'(out_data), 32'(word16(3)));
      chk("unstall_valid", 32'(out_valid), 32'h1);

      // Asynchronous reset with a word in the output slot
      out_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'h0);
      chk("arst_data", 32'(out_data), 32'h0);
      chk("arst_sel", 32'(out_sel), 32'h0);
      chk("arst_in_ready", 32'(in_ready), 32'h0);
      step();
      reset    = 1'b0;
      in_valid = 16'hFFFF;
      #1;
      chk("ptr_reset", 32'(in_ready), 32'h0001);
      in_valid = '0;
      step();

      // Five channels, twelve bits
      rr_en5     = 1'b1;
      in_valid5  = 5'h1F;
      out_ready5 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("n5_sel", 32'(out_sel5), 32'(k % 5));
         chk("n5_data", 32'(out_data5), 32'(word5(k % 5)));
         chk("n5_valid", 32'(out_valid5), 32'h1);
      end
      in_valid5 = '0;
      step();
      chk("n5_drain", 32'(out_valid5), 32'h0);
      rr_en5    = 1'b0;
      fix_sel5  = 3'd6;
      in_valid5 = 5'h1F;
      #1;
      chk("n5_fix6_ready", 32'(in_ready5), 32'h0);
      step();
      chk("n5_fix6_valid", 32'(out_valid5), 32'h0);
      step();
      chk("n5_fix6_valid2", 32'(out_valid5), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
